// File: rtl/vgachargen_map_ctrl.sv
// Map write controller for the character generator: arbitrates host writes against a
// hardware fill engine. Define VGACHARGEN_FILL_COL_EN to make the fill cover col_map too.
module vgachargen_map_ctrl #(
  parameter int unsigned MAP_WORDS = 600,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              host_req_i,
  input  logic              host_sel_col_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [31:0]       host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_err_o,
  input  logic              fill_start_i,
  input  logic [31:0]       fill_ch_data_i,
  input  logic [31:0]       fill_col_data_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic [ADDR_W-1:0] ch_map_addr_o,
  output logic [31:0]       ch_map_data_o,
  output logic              ch_map_wen_o,
  output logic [ADDR_W-1:0] col_map_addr_o,
  output logic [31:0]       col_map_data_o,
  output logic              col_map_wen_o
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MAP_WORDS - 1);

`ifdef VGACHARGEN_FILL_COL_EN
  typedef enum logic [1:0] {IDLE, FILL_CH, FILL_COL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL_CH, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_host_q, rr_host_d;
  logic [31:0]       fill_ch_q, fill_ch_d;
  logic [31:0]       fill_col_q, fill_col_d;
  logic [ADDR_W-1:0] ch_addr_q, ch_addr_d, col_addr_q, col_addr_d;
  logic [31:0]       ch_data_q, ch_data_d, col_data_q, col_data_d;
  logic              ch_wen_q, ch_wen_d, col_wen_q, col_wen_d;
  logic              err_q, err_d;

  logic fill_req, contend, host_win, fill_win;

  always_comb begin
`ifdef VGACHARGEN_FILL_COL_EN
    fill_req = (state_q == FILL_CH) || (state_q == FILL_COL);
`else
    fill_req = (state_q == FILL_CH);
`endif
    contend  = host_req_i && fill_req;
    // rr_host_q set means the host won the last contended cycle, so the fill wins this one
    host_win = host_req_i && (!contend || !rr_host_q);
    fill_win = fill_req && !host_win;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_host_d  = rr_host_q;
    fill_ch_d  = fill_ch_q;
    fill_col_d = fill_col_q;
    ch_addr_d  = ch_addr_q;
    ch_data_d  = ch_data_q;
    col_addr_d = col_addr_q;
    col_data_d = col_data_q;
    ch_wen_d   = 1'b0;
    col_wen_d  = 1'b0;
    err_d      = 1'b0;

    if (contend) rr_host_d = host_win;

    if (host_win) begin
      if (host_addr_i > LAST_WORD) begin
        err_d = 1'b1;
      end else if (host_sel_col_i) begin
        col_addr_d = host_addr_i;
        col_data_d = host_wdata_i;
        col_wen_d  = 1'b1;
      end else begin
        ch_addr_d = host_addr_i;
        ch_data_d = host_wdata_i;
        ch_wen_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          state_d    = FILL_CH;
          cnt_d      = '0;
          fill_ch_d  = fill_ch_data_i;
          fill_col_d = fill_col_data_i;
        end
      end
      FILL_CH: begin
        if (fill_win) begin
          ch_addr_d = cnt_q;
          ch_data_d = fill_ch_q;
          ch_wen_d  = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d = '0;
`ifdef VGACHARGEN_FILL_COL_EN
            state_d = FILL_COL;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
`ifdef VGACHARGEN_FILL_COL_EN
      FILL_COL: begin
        if (fill_win) begin
          col_addr_d = cnt_q;
          col_data_d = fill_col_q;
          col_wen_d  = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_host_q  <= 1'b0;
      fill_ch_q  <= '0;
      fill_col_q <= '0;
      ch_addr_q  <= '0;
      ch_data_q  <= '0;
      ch_wen_q   <= 1'b0;
      col_addr_q <= '0;
      col_data_q <= '0;
      col_wen_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_host_q  <= rr_host_d;
      fill_ch_q  <= fill_ch_d;
      fill_col_q <= fill_col_d;
      ch_addr_q  <= ch_addr_d;
      ch_data_q  <= ch_data_d;
      ch_wen_q   <= ch_wen_d;
      col_addr_q <= col_addr_d;
      col_data_q <= col_data_d;
      col_wen_q  <= col_wen_d;
      err_q      <= err_d;
    end
  end

`ifndef VGACHARGEN_FILL_COL_EN
  logic unused_fill_col;
  assign unused_fill_col = ^fill_col_q;
`endif

  // Grant is combinational; masked while reset holds the controller so no write is implied
  assign host_gnt_o     = host_win && !arst_i;
  assign host_err_o     = err_q;
  assign fill_busy_o    = fill_req;
  assign fill_done_o    = (state_q == DONE);
  assign ch_map_addr_o  = ch_addr_q;
  assign ch_map_data_o  = ch_data_q;
  assign ch_map_wen_o   = ch_wen_q;
  assign col_map_addr_o = col_addr_q;
  assign col_map_data_o = col_data_q;
  assign col_map_wen_o  = col_wen_q;

endmodule

// File: tb/tb_vgachargen_map_ctrl.sv
// Self-checking bench for vgachargen_map_ctrl: host vector table, full fills, contended
// fill and mid-fill reset, with a scoreboard of expected map-port writes.
module tb_vgachargen_map_ctrl;

  localparam int MW = 600;
`ifdef VGACHARGEN_FILL_COL_EN
  localparam int FW = 2 * MW;
`else
  localparam int FW = MW;
`endif

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        host_req_i, host_sel_col_i;
  logic [9:0]  host_addr_i;
  logic [31:0] host_wdata_i;
  logic        host_gnt_o, host_err_o;
  logic        fill_start_i;
  logic [31:0] fill_ch_data_i, fill_col_data_i;
  logic        fill_busy_o, fill_done_o;
  logic [9:0]  ch_map_addr_o, col_map_addr_o;
  logic [31:0] ch_map_data_o, col_map_data_o;
  logic        ch_map_wen_o, col_map_wen_o;

  vgachargen_map_ctrl #(.MAP_WORDS(600), .ADDR_W(10)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .host_req_i(host_req_i), .host_sel_col_i(host_sel_col_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_err_o(host_err_o),
    .fill_start_i(fill_start_i), .fill_ch_data_i(fill_ch_data_i),
    .fill_col_data_i(fill_col_data_i), .fill_busy_o(fill_busy_o),
    .fill_done_o(fill_done_o),
    .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o),
    .ch_map_wen_o(ch_map_wen_o),
    .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o),
    .col_map_wen_o(col_map_wen_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ch_wen;
    logic [9:0]  ch_addr;
    logic [31:0] ch_data;
    logic        col_wen;
    logic [9:0]  col_addr;
    logic [31:0] col_data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        exp_err;
  } hvec_t;

  int tests = 0;
  int failed = 0;

  exp_t sb[$];
  exp_t hold;

  int          m_phase;
  int          m_idx;
  logic        m_last_host;
  logic [31:0] m_fch, m_fcol;
  int          obs_busy, obs_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase     = 0;
    m_idx       = 0;
    m_last_host = 1'b0;
    m_fch       = '0;
    m_fcol      = '0;
    hold        = '{default: '0};
    sb.delete();
  endtask

  task automatic step(input logic hreq, input logic hsel, input logic [9:0] haddr,
                      input logic [31:0] hdata, input logic fstart,
                      input logic [31:0] fch, input logic [31:0] fcol,
                      output logic gnt_exp);
    exp_t e, r;
    logic host_w, fill_w, freq;
    @(negedge clk_i);
    host_req_i      = hreq;
    host_sel_col_i  = hsel;
    host_addr_i     = haddr;
    host_wdata_i    = hdata;
    fill_start_i    = fstart;
    fill_ch_data_i  = fch;
    fill_col_data_i = fcol;
    #1;
    chk("busy", fill_busy_o, m_phase == 1);
    chk("done", fill_done_o, m_phase == 2);
    if (fill_busy_o) obs_busy++;
    if (fill_done_o) obs_done++;

    freq = (m_phase == 1);
    if (hreq && freq) begin
      host_w      = !m_last_host;
      m_last_host = host_w;
    end else begin
      host_w = hreq;
    end
    fill_w = freq && !host_w;
    chk("gnt", host_gnt_o, host_w);

    e = hold;
    e.ch_wen = 1'b0; e.col_wen = 1'b0; e.err = 1'b0;
    if (host_w) begin
      if (haddr >= 10'd600) e.err = 1'b1;
      else if (hsel) begin e.col_wen = 1'b1; e.col_addr = haddr; e.col_data = hdata; end
      else begin e.ch_wen = 1'b1; e.ch_addr = haddr; e.ch_data = hdata; end
    end
    if (fill_w) begin
      if (m_idx < MW) begin e.ch_wen = 1'b1; e.ch_addr = 10'(m_idx); e.ch_data = m_fch; end
      else begin e.col_wen = 1'b1; e.col_addr = 10'(m_idx - MW); e.col_data = m_fcol; end
      m_idx++;
    end

    if (m_phase == 2) m_phase = 0;
    else if (m_phase == 0 && fstart) begin
      m_phase = 1; m_idx = 0; m_fch = fch; m_fcol = fcol;
    end else if (m_phase == 1 && m_idx == FW) m_phase = 2;

    hold = e;
    sb.push_back(e);
    gnt_exp = host_w;

    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      r = sb.pop_front();
      chk("ch_wen",   ch_map_wen_o,   r.ch_wen);
      chk("ch_addr",  ch_map_addr_o,  r.ch_addr);
      chk("ch_data",  ch_map_data_o,  r.ch_data);
      chk("col_wen",  col_map_wen_o,  r.col_wen);
      chk("col_addr", col_map_addr_o, r.col_addr);
      chk("col_data", col_map_data_o, r.col_data);
      chk("err",      host_err_o,     r.err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},  host_gnt_o,  0);
    chk({tag, "_err"},  host_err_o,  0);
    chk({tag, "_busy"}, fill_busy_o, 0);
    chk({tag, "_done"}, fill_done_o, 0);
    chk({tag, "_chw"},  ch_map_wen_o, 0);
    chk({tag, "_cha"},  ch_map_addr_o, 0);
    chk({tag, "_chd"},  ch_map_data_o, 0);
    chk({tag, "_colw"}, col_map_wen_o, 0);
    chk({tag, "_cola"}, col_map_addr_o, 0);
    chk({tag, "_cold"}, col_map_data_o, 0);
  endtask

  initial begin
    hvec_t vecs[7];
    logic  g;
    int    budget;
    logic        p_sel;
    logic [9:0]  p_addr;
    logic [31:0] p_data;

    vecs[0] = '{sel: 1'b0, addr: 10'd5,    data: 32'h4142_4344, exp_err: 1'b0};
    vecs[1] = '{sel: 1'b1, addr: 10'd17,   data: 32'h0F1E_2D3C, exp_err: 1'b0};
    vecs[2] = '{sel: 1'b0, addr: 10'd599,  data: 32'hDEAD_BEEF, exp_err: 1'b0};
    vecs[3] = '{sel: 1'b1, addr: 10'd0,    data: 32'h1234_5678, exp_err: 1'b0};
    vecs[4] = '{sel: 1'b0, addr: 10'd600,  data: 32'hFFFF_FFFF, exp_err: 1'b1};
    vecs[5] = '{sel: 1'b1, addr: 10'd1023, data: 32'hAAAA_5555, exp_err: 1'b1};
    vecs[6] = '{sel: 1'b1, addr: 10'd599,  data: 32'hCAFE_F00D, exp_err: 1'b0};

    arst_i = 1'b1;
    host_req_i = 1'b1; host_sel_col_i = 1'b0; host_addr_i = 10'd3; host_wdata_i = 32'h1;
    fill_start_i = 1'b0; fill_ch_data_i = '0; fill_col_data_i = '0;
    obs_busy = 0; obs_done = 0;
    model_reset();
    #23;
    check_all_zero("reset");
    @(negedge clk_i);
    arst_i = 1'b0;
    host_req_i = 1'b0;

    // host vector table, no fill
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].sel, vecs[i].addr, vecs[i].data, 1'b0, '0, '0, g);
      chk("vec_err", host_err_o, vecs[i].exp_err);
    end

    // uncontended fill with a stray fill_start mid-fill that must be ignored
    obs_busy = 0; obs_done = 0;
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'h2020_2020, 32'h0F0F_0F0F, g);
    budget = 0;
    while (m_phase != 0 && budget < 3000) begin
      step(1'b0, 1'b0, '0, '0, (budget == 10), 32'h5555_5555, 32'h6666_6666, g);
      budget++;
    end
    chk("fill_timeout", m_phase, 0);
    chk("fill_busy_cycles", obs_busy, FW);
    chk("fill_done_pulses", obs_done, 1);

    // reset asserted at fill word 300
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'h3131_3131, 32'h7070_7070, g);
    budget = 0;
    while (m_idx < 300 && budget < 1000) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, g);
      budget++;
    end
    chk("midfill_idx", m_idx, 300);
    @(negedge clk_i);
    host_req_i = 1'b1; host_addr_i = 10'd9;
    arst_i = 1'b1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk_i);
    arst_i = 1'b0;
    host_req_i = 1'b0;
    obs_busy = 0; obs_done = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, g);
    chk("no_resume_busy", obs_busy, 0);
    chk("no_done_after_reset", obs_done, 0);

    // restarted fill with continuous host traffic; first contention goes to host
    obs_busy = 0; obs_done = 0;
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, g);
    p_sel = 1'($urandom_range(0, 1)); p_addr = 10'($urandom_range(0, 599)); p_data = $urandom;
    budget = 0;
    while (m_phase != 0 && budget < 5000) begin
      step(1'b1, p_sel, p_addr, p_data, 1'b0, '0, '0, g);
      if (g) begin
        p_sel = 1'($urandom_range(0, 1)); p_addr = 10'($urandom_range(0, 599)); p_data = $urandom;
      end
      budget++;
    end
    chk("contend_timeout", m_phase, 0);
    chk("contend_busy_cycles", obs_busy, 2 * FW);
    chk("contend_done_pulses", obs_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vgachargen_map_ctrl.md
VGACHARGEN_MAP_CTRL -- requirements
Module: vgachargen_map_ctrl

Interface
REQ-001 SHALL provide parameters: MAP_WORDS, 600, words per map (2400 chars / 4 per word); ADDR_W, 10, map address width.
REQ-002 SHALL have one clock; reset is asynchronous and active-high: clk_i input 1 clock (rising edge); arst_i input 1 asynchronous active-high reset.
REQ-003 SHALL provide host_req_i input 1 host write request, held until granted; host_sel_col_i input 1 target map (0 ch_map, 1 col_map); host_addr_i input ADDR_W word address; host_wdata_i input 32 write data.
REQ-004 SHALL provide host_gnt_o output 1 combinational grant; host_err_o output 1 one-cycle pulse, out-of-range host address.
REQ-005 SHALL provide fill_start_i input 1 fill start pulse; fill_ch_data_i input 32 ch_map fill word; fill_col_data_i input 32 col_map fill word; fill_busy_o output 1 fill in progress; fill_done_o output 1 one-cycle completion pulse.
REQ-006 SHALL provide ch_map_addr_o output ADDR_W, ch_map_data_o output 32, ch_map_wen_o output 1; col_map_addr_o output ADDR_W, col_map_data_o output 32, col_map_wen_o output 1 (all registered, drive the character generator map ports).

Function
REQ-007 SHALL implement FSM states IDLE, FILL_CH, FILL_COL, DONE.
REQ-008 IDLE -> FILL_CH on fill_start_i=1; fill data words captured into internal registers in that cycle.
REQ-009 FILL_CH -> FILL_COL when ch_map word MAP_WORDS-1 is issued; FILL_COL -> DONE when col_map word MAP_WORDS-1 is issued; DONE -> IDLE unconditionally after one cycle.
REQ-010 fill_busy_o SHALL be 1 in FILL_CH and FILL_COL only; fill_done_o SHALL be 1 in DONE only.
REQ-011 fill_start_i outside IDLE SHALL be ignored.
REQ-012 Fill address counter SHALL start at 0, increment by 1 per granted fill write, reset to 0 on entry to each fill state; no wrap beyond MAP_WORDS-1.
REQ-013 One write per cycle total across both maps; arbiter SHALL be two-way round-robin between host and fill.
REQ-014 Contention (host_req_i=1 and FSM in fill state): winner is requester not granted in previous contended cycle; first contention after reset goes to host.
REQ-015 No contention: sole requester granted every cycle; fill not granted holds counter and state.
REQ-016 Granted write in cycle N SHALL appear on the selected map's addr/data/wen outputs in cycle N+1 with wen high one cycle; the other map's wen stays 0.
REQ-017 Host request with host_addr_i >= MAP_WORDS SHALL be granted, produce no wen, and pulse host_err_o in cycle N+1.
REQ-018 addr/data outputs SHALL hold last value when wen=0.

Reset
REQ-019 arst_i=1 SHALL immediately force FSM to IDLE, counter 0, round-robin pointer to host, all outputs 0, including mid-fill; fill not resumed after release.
REQ-020 First grant possible in first rising edge after arst_i deasserts.

Configuration
REQ-021 Macro VGACHARGEN_FILL_COL_EN defined: fill covers ch_map then col_map per REQ-009.
REQ-022 Macro undefined: FILL_COL state absent; FILL_CH -> DONE after word MAP_WORDS-1; fill_col_data_i ignored; col_map written only by host.

Verification
REQ-023 Reset then host write ch_map addr 5 data 32'h4142_4344, no fill -> gnt same cycle; next cycle ch_map_addr_o=5, data=32'h4142_4344, ch_map_wen_o=1, col_map_wen_o=0.
REQ-024 fill_start_i with ch 32'h2020_2020, col 32'h0F0F_0F0F, no host traffic (macro defined) -> 600 ch_map writes addr 0..599, then 600 col_map writes, fill_done_o pulse exactly once, busy 1200 cycles.
REQ-025 Host requests continuously during fill -> grants alternate host/fill each cycle; fill completes in 1200 fill grants, no address skipped or repeated.
REQ-026 Host write addr 600 -> host_gnt_o=1, no wen, host_err_o=1 one cycle.
REQ-027 arst_i pulsed at fill word 300 -> outputs 0 immediately, fill_busy_o=0, no fill_done_o; new fill_start_i restarts at addr 0.
REQ-028 Macro undefined, fill_start_i -> 600 ch_map writes only, fill_done_o after addr 599, col_map_wen_o never 1.
